seg_display_arbiter: RTL

SEG_DISPLAY_ARBITER -- requirements
Module: seg_display_arbiter

---
 rtl/seg_display_arbiter.sv | 84 ++++++++
 1 files changed

// File: rtl/seg_display_arbiter.sv
// seg_display_arbiter: round-robin owner of a 4-digit 7-segment display with minimum hold,
// blanking gap between owners and multiplexed digit scan.
module seg_display_arbiter #(
  parameter int SCAN_DIV     = 4096,
  parameter int HOLD_CYCLES  = 2**24,
  parameter int BLANK_CYCLES = 1024
) (
  input  logic        i_Clk,
  input  logic        i_Rst_n,
  input  logic [2:0]  i_Req,
  input  logic [15:0] i_Data0,
  input  logic [15:0] i_Data1,
  input  logic [15:0] i_Data2,
  output logic [2:0]  o_Grant,
  output logic [3:0]  o_Drains,
  output logic [7:0]  o_Leds
);
  typedef enum logic [1:0] {IDLE, OWN, BLANK} state_t;
  localparam logic [127:0] GLYPHS = {8'h71, 8'h79, 8'h5E, 8'h39, 8'h7C, 8'h77, 8'h6F, 8'h7F,
                                     8'h07, 8'h7D, 8'h6D, 8'h66, 8'h4F, 8'h5B, 8'h06, 8'h3F};
  state_t      state_q;
  logic [2:0]  grant_q;
  logic [1:0]  last_q, dig_q;
  logic [26:0] hold_q;
  logic [15:0] blank_q, pre_q;
  logic [3:0]  drains_q;
  logic [7:0]  leds_q;
  logic [1:0]  n1, n2, pick;
  logic [15:0] data;
  logic [3:0]  nib;
  logic        rel, go;
  // last_q doubles as the owner index while in OWN
  always_comb begin
    n1   = last_q == 2'd2 ? 2'd0 : last_q + 2'd1;
    n2   = n1 == 2'd2 ? 2'd0 : n1 + 2'd1;
    pick = i_Req[n1] ? n1 : i_Req[n2] ? n2 : last_q;
    data = last_q == 2'd0 ? i_Data0 : last_q == 2'd1 ? i_Data1 : i_Data2;
    nib  = data[{dig_q, 2'b00} +: 4];
    rel  = hold_q == '0 && (!(|(i_Req & grant_q)) || (|(i_Req & ~grant_q)));
    go   = (state_q == IDLE || (state_q == BLANK && blank_q == '0)) && (|i_Req);
  end
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      last_q   <= 2'd2;
      dig_q    <= '0;
      hold_q   <= '0;
      blank_q  <= '0;
      pre_q    <= '0;
      drains_q <= '0;
      leds_q   <= '0;
    end else begin
      drains_q <= '0;
      leds_q   <= '0;
      if (go) begin
        state_q <= OWN;
        grant_q <= 3'b001 << pick;
        last_q  <= pick;
        hold_q  <= 27'(HOLD_CYCLES - 1);
        dig_q   <= '0;
        pre_q   <= '0;
      end else if (state_q == OWN && rel) begin
        state_q <= BLANK;
        grant_q <= '0;
        blank_q <= 16'(BLANK_CYCLES - 1);
      end else if (state_q == OWN) begin
        hold_q   <= hold_q == '0 ? '0 : hold_q - 27'd1;
        pre_q    <= pre_q == 16'(SCAN_DIV - 1) ? '0 : pre_q + 16'd1;
        dig_q    <= pre_q == 16'(SCAN_DIV - 1) ? dig_q + 2'd1 : dig_q;
        drains_q <= 4'b0001 << dig_q;
        leds_q   <= GLYPHS[{nib, 3'b000} +: 8];
      end else if (state_q == BLANK) begin
        state_q <= blank_q == '0 ? IDLE : BLANK;
        blank_q <= blank_q == '0 ? '0 : blank_q - 16'd1;
      end else begin
        state_q <= IDLE;
      end
    end
  end
  assign o_Grant  = grant_q;
  assign o_Drains = drains_q;
  assign o_Leds   = leds_q;
endmodule
